// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU with start/done handshake: single-cycle logic/compare ops, shift-add multiply
// and, when ULA_DIV_EN is defined, a restoring divider.
module ula_multiciclo #(
  parameter int unsigned LARGURA = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inicio,
  input  logic [2:0]         sel,
  input  logic [2:0]         comp,
  input  logic [LARGURA-1:0] enta,
  input  logic [LARGURA-1:0] entb,
  output logic [LARGURA-1:0] resultado,
  output logic [LARGURA-1:0] resto,
  output logic               zero,
  output logic               ocupado,
  output logic               pronto
);

  localparam int unsigned CW = $clog2(LARGURA);

  localparam logic [1:0] OCIOSO = 2'd0;
  localparam logic [1:0] MULT   = 2'd1;
`ifdef ULA_DIV_EN
  localparam logic [1:0] DIV    = 2'd2;
`endif

  logic [1:0]         estado_q, estado_d;
  logic [LARGURA-1:0] resultado_q, resultado_d;
  logic [LARGURA-1:0] resto_q, resto_d;
  logic               pronto_q, pronto_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // a_q: multiplicand (mult) or dividend/quotient (div); b_q: multiplier or divisor;
  // acc_q: partial product or partial remainder.
  logic [LARGURA-1:0] a_q, a_d;
  logic [LARGURA-1:0] b_q, b_d;
  logic [LARGURA-1:0] acc_q, acc_d;
  logic [LARGURA-1:0] soma;
  logic               cmp_bit;
  logic               ultimo;

  assign ultimo = (cnt_q == CW'(LARGURA - 1));
  assign soma   = acc_q + (b_q[0] ? a_q : '0);

`ifdef ULA_DIV_EN
  logic [LARGURA:0] tentativa;
  assign tentativa = {acc_q, a_q[LARGURA-1]} - {1'b0, b_q};
`endif

  always_comb begin
    cmp_bit = 1'b0;
    unique case (comp)
      3'b001:  cmp_bit = (enta != entb);
      3'b010:  cmp_bit = (enta == entb);
      3'b011:  cmp_bit = (enta >= entb);
      3'b100:  cmp_bit = (enta <= entb);
      3'b101:  cmp_bit = (enta != '0);
      3'b111:  cmp_bit = (enta != LARGURA'(1));
      default: cmp_bit = 1'b0;
    endcase
  end

  always_comb begin
    estado_d    = estado_q;
    resultado_d = resultado_q;
    resto_d     = resto_q;
    pronto_d    = 1'b0;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;

    unique case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          if (comp != 3'b000 && comp != 3'b110) begin
            resultado_d = {{(LARGURA-1){1'b0}}, cmp_bit};
            resto_d     = '0;
            pronto_d    = 1'b1;
          end else begin
            resto_d  = '0;
            pronto_d = 1'b1;
            unique case (sel)
              3'b000: resultado_d = enta + entb;
              3'b001: resultado_d = enta - entb;
              3'b010: resultado_d = enta & entb;
              3'b011: resultado_d = enta | entb;
              3'b111: resultado_d = enta;
              3'b100: begin
                estado_d = MULT;
                pronto_d = 1'b0;
                resto_d  = resto_q;
                a_d      = enta;
                b_d      = entb;
                acc_d    = '0;
                cnt_d    = '0;
              end
`ifdef ULA_DIV_EN
              3'b110: begin
                estado_d = DIV;
                pronto_d = 1'b0;
                resto_d  = resto_q;
                a_d      = enta;
                b_d      = entb;
                acc_d    = '0;
                cnt_d    = '0;
              end
              3'b101: resultado_d = resultado_q;
`else
              3'b101, 3'b110: resultado_d = resultado_q;
`endif
              default: resultado_d = resultado_q;
            endcase
          end
        end
      end
      MULT: begin
        acc_d = soma;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (ultimo) begin
          estado_d    = OCIOSO;
          resultado_d = soma;
          resto_d     = '0;
          pronto_d    = 1'b1;
          cnt_d       = '0;
        end
      end
`ifdef ULA_DIV_EN
      DIV: begin
        // Restore on borrow; a zero divisor never borrows, giving all-ones and resto = enta.
        if (!tentativa[LARGURA]) begin
          acc_d = tentativa[LARGURA-1:0];
          a_d   = {a_q[LARGURA-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[LARGURA-2:0], a_q[LARGURA-1]};
          a_d   = {a_q[LARGURA-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (ultimo) begin
          estado_d    = OCIOSO;
          resultado_d = a_d;
          resto_d     = acc_d;
          pronto_d    = 1'b1;
          cnt_d       = '0;
        end
      end
`endif
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= OCIOSO;
      resultado_q <= '0;
      resto_q     <= '0;
      pronto_q    <= 1'b0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
    end else begin
      estado_q    <= estado_d;
      resultado_q <= resultado_d;
      resto_q     <= resto_d;
      pronto_q    <= pronto_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
    end
  end

  assign resultado = resultado_q;
  assign resto     = resto_q;
  assign pronto    = pronto_q;
  assign ocupado   = (estado_q != OCIOSO);
  assign zero      = (resultado_q == '0);

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed self-checking bench for ula_multiciclo at LARGURA=32.
module tb_ula_multiciclo;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         inicio = 1'b0;
  logic [2:0]   sel = 3'b000;
  logic [2:0]   comp = 3'b000;
  logic [W-1:0] enta = '0;
  logic [W-1:0] entb = '0;
  logic [W-1:0] resultado;
  logic [W-1:0] resto;
  logic         zero;
  logic         ocupado;
  logic         pronto;

  int tests = 0;
  int fails = 0;

  ula_multiciclo #(.LARGURA(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inicio    (inicio),
    .sel       (sel),
    .comp      (comp),
    .enta      (enta),
    .entb      (entb),
    .resultado (resultado),
    .resto     (resto),
    .zero      (zero),
    .ocupado   (ocupado),
    .pronto    (pronto)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one op, scramble operands afterwards, then wait (bounded) for pronto.
  task automatic issue(input logic [2:0] s, input logic [2:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int lat);
    sel = s; comp = c; enta = a; entb = b; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0; enta = ~a; entb = ~b;
    lat = 1;
    while (pronto !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat;
  int occ;

  initial begin
    #12;
    chk("rst_resultado", resultado, 32'h0);
    chk("rst_resto", resto, 32'h0);
    chk("rst_zero", zero, 32'h1);
    chk("rst_pronto", pronto, 32'h0);
    chk("rst_ocupado", ocupado, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_pronto", pronto, 32'h0);

    // add wraps to zero, then sub issued while pronto is high
    sel = 3'b000; comp = 3'b000; enta = 32'hFFFF_FFFF; entb = 32'h1; inicio = 1'b1;
    @(posedge clk); #1;
    chk("add_pronto", pronto, 32'h1);
    chk("add_res", resultado, 32'h0);
    chk("add_zero", zero, 32'h1);
    sel = 3'b001; enta = 32'd5; entb = 32'd7;
    @(posedge clk); #1;
    inicio = 1'b0;
    chk("sub_pronto", pronto, 32'h1);
    chk("sub_res", resultado, 32'hFFFF_FFFE);
    chk("sub_zero", zero, 32'h0);
    @(posedge clk); #1;
    chk("sub_pronto_low", pronto, 32'h0);

    // multiply with a stray inicio mid-operation
    sel = 3'b100; comp = 3'b000; enta = 32'h0001_0003; entb = 32'h5; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0; enta = '0; entb = '0;
    chk("mul_ocupado", ocupado, 32'h1);
    lat = 1; occ = 0;
    while (pronto !== 1'b1 && lat < 100) begin
      if (ocupado) occ++;
      if (lat == 10) begin
        inicio = 1'b1; sel = 3'b000; enta = 32'h1; entb = 32'h1;
      end else begin
        inicio = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    inicio = 1'b0;
    chk("mul_latency", 32'(lat), 32'd33);
    chk("mul_occ_cycles", 32'(occ), 32'd32);
    chk("mul_ocupado_end", ocupado, 32'h0);
    chk("mul_res", resultado, 32'h0005_000F);
    chk("mul_resto", resto, 32'h0);
    @(posedge clk); #1;
    chk("mul_pronto_low", pronto, 32'h0);

`ifdef ULA_DIV_EN
    issue(3'b110, 3'b000, 32'd100, 32'd7, lat);
    chk("div_latency", 32'(lat), 32'd33);
    chk("div_res", resultado, 32'd14);
    chk("div_resto", resto, 32'd2);
    issue(3'b110, 3'b000, 32'd9, 32'd0, lat);
    chk("div0_latency", 32'(lat), 32'd33);
    chk("div0_res", resultado, 32'hFFFF_FFFF);
    chk("div0_resto", resto, 32'd9);
    issue(3'b000, 3'b000, 32'd1, 32'd1, lat);
    chk("after_div_resto", resto, 32'h0);
`else
    issue(3'b110, 3'b000, 32'd1, 32'd2, lat);
    chk("nodiv_latency", 32'(lat), 32'd1);
    chk("nodiv_res", resultado, 32'h0005_000F);
    chk("nodiv_resto", resto, 32'h0);
    chk("nodiv_ocupado", ocupado, 32'h0);
`endif

    // compares override sel (sel=add would give 6)
    issue(3'b000, 3'b001, 32'd3, 32'd3, lat);
    chk("beq_res", resultado, 32'd0);
    chk("beq_zero", zero, 32'h1);
    chk("beq_latency", 32'(lat), 32'd1);
    issue(3'b000, 3'b010, 32'd3, 32'd3, lat);
    chk("bneq_res", resultado, 32'd1);
    issue(3'b000, 3'b011, 32'd3, 32'd3, lat);
    chk("sgt_res", resultado, 32'd1);
    issue(3'b000, 3'b011, 32'd2, 32'd3, lat);
    chk("sgt_lt_res", resultado, 32'd0);
    issue(3'b000, 3'b100, 32'd3, 32'd3, lat);
    chk("slt_res", resultado, 32'd1);
    issue(3'b000, 3'b101, 32'd3, 32'd3, lat);
    chk("beqz_res", resultado, 32'd1);
    issue(3'b000, 3'b111, 32'd1, 32'd3, lat);
    chk("beqo_res", resultado, 32'd0);
    issue(3'b010, 3'b110, 32'h0000_00F0, 32'h0000_003C, lat);
    chk("and_comp110_res", resultado, 32'h0000_0030);
    issue(3'b011, 3'b000, 32'h0000_00F0, 32'h0000_000F, lat);
    chk("or_res", resultado, 32'h0000_00FF);
    issue(3'b111, 3'b000, 32'hDEAD_BEEF, 32'h1, lat);
    chk("mov_res", resultado, 32'hDEAD_BEEF);
    issue(3'b101, 3'b000, 32'h1, 32'h1, lat);
    chk("keep_res", resultado, 32'hDEAD_BEEF);

    // reset mid-multiply
    issue(3'b000, 3'b000, 32'h10, 32'h20, lat);
    chk("pre_rst_res", resultado, 32'h30);
    sel = 3'b100; comp = 3'b000; enta = 32'h0001_0003; entb = 32'h5; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_mul_ocupado", ocupado, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mrst_resultado", resultado, 32'h0);
    chk("mrst_resto", resto, 32'h0);
    chk("mrst_zero", zero, 32'h1);
    chk("mrst_pronto", pronto, 32'h0);
    chk("mrst_ocupado", ocupado, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(3'b000, 3'b000, 32'd2, 32'd2, lat);
    chk("post_rst_latency", 32'(lat), 32'd1);
    chk("post_rst_res", resultado, 32'd4);
    chk("post_rst_ocupado", ocupado, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
